// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS32 fetch front end with 4-entry prefetch FIFO
//
// Owns the PC, issues in-order word fetches over a req/gnt + rvalid handshake,
// buffers returned words and drives the IF/ID register seen by decode.
// Ports:
//   Clk, Rst_n                 clock, synchronous active-low reset
//   ID_PCSrc, ID_new_PC        redirect from decode (flushes all younger fetches)
//   Stall                      hold IF/ID
//   IMem_Req/Addr/Gnt          fetch request channel
//   IMem_RValid/RData          in-order fetch response channel
//   IF_ID_Instruction/PC4/Valid  pipeline register to decode
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ID_PCSrc,
    input  logic [31:0] ID_new_PC,
    input  logic        Stall,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Gnt,
    input  logic        IMem_RValid,
    input  logic [31:0] IMem_RData,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [2:0]  out_q, out_d;
    logic [2:0]  kill_q, kill_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc4_q [4];
    logic [31:0] fifo_ins_q [4];
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_ins_q, ifid_ins_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic [31:0] target;
    logic [3:0]  credit;
    logic        req;
    logic        issue;
    logic        resp;
    logic        live;
    logic        fifo_push;
    logic        fifo_pop;

    assign target = {ID_new_PC[31:2], 2'b00};

    // Words already buffered plus live requests in flight; dead (killed)
    // requests will be dropped on return so they do not consume FIFO space.
    assign credit = {1'b0, cnt_q} + {1'b0, out_q} - {1'b0, kill_q};

    assign req   = Rst_n & ~ID_PCSrc & (credit < 4'd4) & (out_q < 3'd4);
    assign issue = req & IMem_Gnt;
    assign resp  = IMem_RValid;
    assign live  = resp & (kill_q == 3'd0) & ~ID_PCSrc;

    assign IMem_Req          = req;
    assign IMem_Addr         = pc_q;
    assign IF_ID_Instruction = ifid_ins_q;
    assign IF_ID_PC4         = ifid_pc4_q;
    assign IF_ID_Valid       = ifid_valid_q;

    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        out_d        = out_q + {2'b00, issue} - {2'b00, resp};
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_ins_d   = ifid_ins_q;
        ifid_pc4_d   = ifid_pc4_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;

        if (ID_PCSrc) begin
            pc_d      = target;
            resp_pc_d = target;
            // Everything still in flight belongs to the wrong path.
            kill_d    = out_q - {2'b00, resp};
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (live) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (resp && kill_q != 3'd0) begin
                kill_d = kill_q - 3'd1;
            end
        end

        if (ID_PCSrc) begin
            ifid_valid_d = 1'b0;
            ifid_ins_d   = 32'd0;
            ifid_pc4_d   = 32'd0;
        end else if (Stall) begin
            fifo_push = live;
        end else if (cnt_q != 3'd0) begin
            ifid_valid_d = 1'b1;
            ifid_ins_d   = fifo_ins_q[rd_ptr_q];
            ifid_pc4_d   = fifo_pc4_q[rd_ptr_q];
            fifo_pop     = 1'b1;
            fifo_push    = live;
        end else if (live) begin
            // Empty FIFO: the response goes straight into IF/ID.
            ifid_valid_d = 1'b1;
            ifid_ins_d   = IMem_RData;
            ifid_pc4_d   = resp_pc_q + 32'd4;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_ins_d   = 32'd0;
            ifid_pc4_d   = 32'd0;
        end

        if (ID_PCSrc) begin
            cnt_d    = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end else begin
            cnt_d    = cnt_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
            rd_ptr_d = rd_ptr_q + {1'b0, fifo_pop};
            wr_ptr_d = wr_ptr_q + {1'b0, fifo_push};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            out_q        <= 3'd0;
            kill_q       <= 3'd0;
            cnt_q        <= 3'd0;
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            ifid_valid_q <= 1'b0;
            ifid_ins_q   <= 32'd0;
            ifid_pc4_q   <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            out_q        <= out_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_ins_q   <= ifid_ins_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge Clk) begin
        if (Rst_n && fifo_push) begin
            fifo_pc4_q[wr_ptr_q] <= resp_pc_q + 32'd4;
            fifo_ins_q[wr_ptr_q] <= IMem_RData;
        end
    end

    // The credit rule must never let a push land on a full buffer.
    always_ff @(posedge Clk) begin
        if (Rst_n && fifo_push) begin
            assert (cnt_q != 3'd4);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] new_pc = 32'd0;
    logic        stall = 1'b0;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        valid;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .Clk(clk), .Rst_n(rst_n), .ID_PCSrc(pcsrc), .ID_new_PC(new_pc), .Stall(stall),
        .IMem_Req(req), .IMem_Addr(addr), .IMem_Gnt(gnt),
        .IMem_RValid(rvalid), .IMem_RData(rdata),
        .IF_ID_Instruction(ins), .IF_ID_PC4(pc4), .IF_ID_Valid(valid)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct { logic [31:0] a; int due; } pend_t;
    typedef struct { logic [31:0] pc4; logic [31:0] ins; } exp_t;
    pend_t pend[$];
    exp_t  sb[$];

    logic        cur_valid = 1'b0;
    logic [31:0] cur_pc4 = 32'd0;
    logic [31:0] cur_ins = 32'd0;
    logic        s_req;
    logic [31:0] s_addr;

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc4;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: memory response + grant bookkeeping, then IF/ID scoreboard check.
    task automatic step();
        pend_t p;
        exp_t  e;
        rvalid = 1'b0;
        rdata  = 32'd0;
        if (!rst_n) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend[0].a);
            void'(pend.pop_front());
        end
        if (!rst_n || pcsrc) sb.delete();
        #1;
        s_req  = req;
        s_addr = addr;
        if (rst_n && req && gnt) begin
            p.a = addr; p.due = cyc + lat; pend.push_back(p);
            e.pc4 = addr + 32'd4; e.ins = mem_word(addr); sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!rst_n || pcsrc || stall) begin
            if (!rst_n || pcsrc) begin
                cur_valid = 1'b0; cur_pc4 = 32'd0; cur_ins = 32'd0;
            end
            check("ifid_valid", {31'd0, valid}, {31'd0, cur_valid});
            check("ifid_pc4", pc4, cur_pc4);
            check("ifid_instr", ins, cur_ins);
        end else if (valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_empty: valid pc4=%h but no fetch expected", pc4);
                cur_valid = 1'b0; cur_pc4 = 32'd0; cur_ins = 32'd0;
            end else begin
                e = sb.pop_front();
                cur_valid = 1'b1; cur_pc4 = e.pc4; cur_ins = e.ins;
                check("sb_pc4", pc4, e.pc4);
                check("sb_instr", ins, e.ins);
            end
        end else begin
            cur_valid = 1'b0; cur_pc4 = 32'd0; cur_ins = 32'd0;
            check("bubble_pc4", pc4, 32'd0);
            check("bubble_instr", ins, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_pc4;
        int          nb;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, RPC,          1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, RPC,          1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, RPC + 32'h04, 1'b1, RPC + 32'h04};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, RPC + 32'h08, 1'b1, RPC + 32'h08};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, RPC + 32'h0C, 1'b1, RPC + 32'h0C};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, RPC + 32'h10, 1'b1, RPC + 32'h10};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, RPC + 32'h14, 1'b1, RPC + 32'h14};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, RPC + 32'h14, 1'b0, 32'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, RPC + 32'h14, 1'b0, 32'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, RPC + 32'h14, 1'b0, 32'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, RPC + 32'h18, 1'b1, RPC + 32'h18};

        rst_n = 1'b0;
        step();
        step();

        // Reset release, zero-wait streaming, then a 3-cycle grant stall.
        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n;
            gnt   = tbl[i].gnt;
            step();
            check($sformatf("tbl%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].req});
            check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
            check($sformatf("tbl%0d_pc4", i), pc4, tbl[i].pc4);
        end
        gnt = 1'b1;
        repeat (3) step();

        // Stall held for 8 cycles: request drops once credits run out, then drain.
        hold_pc4 = cur_pc4;
        stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("stall%0d_req", k), {31'd0, s_req}, (k < 3) ? 32'd1 : 32'd0);
        end
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("drain%0d_valid", k), {31'd0, valid}, 32'd1);
            if (k == 0) check("drain_first_pc4", pc4, hold_pc4 + 32'd4);
        end

        // Redirect with two live requests outstanding at latency 3; target has low bits set.
        lat = 3;
        repeat (8) step();
        pcsrc  = 1'b1;
        new_pc = 32'h0000_1003;
        step();
        pcsrc = 1'b0;
        nb = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (n == 0) begin
                check("redir_req", {31'd0, s_req}, 32'd1);
                check("redir_addr", s_addr, 32'h0000_1000);
            end
            if (valid) break;
            nb++;
        end
        check("redir_bubbles", nb, 32'd3);
        check("redir_valid", {31'd0, valid}, 32'd1);
        check("redir_pc4", pc4, 32'h0000_1004);
        check("redir_instr", ins, mem_word(32'h0000_1000));
        lat = 1;
        repeat (4) step();

        // Redirect and stall together, with a response arriving in that cycle.
        stall = 1'b1;
        repeat (2) step();
        pcsrc  = 1'b1;
        new_pc = 32'h0000_2000;
        step();
        pcsrc = 1'b0;
        stall = 1'b0;
        step();
        check("ps_req", {31'd0, s_req}, 32'd1);
        check("ps_addr", s_addr, 32'h0000_2000);
        check("ps_bubble", {31'd0, valid}, 32'd0);
        step();
        check("ps_valid", {31'd0, valid}, 32'd1);
        check("ps_pc4", pc4, 32'h0000_2004);
        check("ps_instr", ins, mem_word(32'h0000_2000));
        repeat (3) step();

        // One-cycle reset in mid-stream with three words buffered.
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        rst_n = 1'b0;
        step();
        check("rst_req_low", {31'd0, s_req}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_addr", s_addr, RPC);
        check("rst_req", {31'd0, s_req}, 32'd1);
        check("rst_bubble", {31'd0, valid}, 32'd0);
        step();
        check("rst_valid", {31'd0, valid}, 32'd1);
        check("rst_pc4", pc4, RPC + 32'd4);
        check("rst_instr", ins, mem_word(RPC));
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
